sq_sched: RTL and testbench
===========================

# sq_sched

Round-robin scheduler that shares one multi-cycle shift-add squarer among N requesters. Each requester presents an unsigned W-bit operand with a valid/ready handshake. The block grants one requester at a time and computes the square over W cycles, one partial product per cycle. It returns the 2W-bit result tagged with the requester index on a valid/ready response port. It sits between the requesting datapaths and the shared squarer resource.

## Interface
- N_REQ, 4, number of requesters (≥2)
- W, 3, operand width in bits
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*W  packed operands; requester i at bits [i*W +: W]
- req_ready  out  N_REQ  one-hot accept strobe; never more than one bit high
- rsp_valid  out  1  result valid
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns rsp_data
- rsp_data  out  2*W  unsigned square of the accepted operand
- rsp_ready  in  1  downstream accepts the result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - if any req_valid is high, the round-robin winner gets its req_ready bit high combinationally in this cycle.
  - Its operand is latched into op, and its index into id_q.
  - acc clears to 0, step clears to 0, and the FSM moves to CALC.
- The block samples req_data only on the accept cycle. A requester must hold req_valid and req_data until its req_ready bit is seen high.
- Round-robin:
  - Pointer last is reset to N_REQ-1, so requester 0 wins first.
  - Search order is last+1, last+2, … mod N_REQ.
  - last updates to the winner only on accept.
- CALC:
  - Runs for exactly W cycles, with step = 0..W-1.
  - Each cycle: acc <= acc + (op[step] ? (op << step) : 0).
  - Arithmetic is 2W bits wide with no overflow possible; the maximum is (2^W-1)^2, which is 49 for W=3.
  - After step W-1, the FSM goes to RESP.
- RESP:
  - rsp_valid = 1, rsp_data = acc, rsp_id = id_q.
  - All three are held stable until rsp_ready is high.
  - On a cycle with rsp_valid & rsp_ready, the FSM goes to IDLE.
  - No new request is accepted in RESP.
- While not IDLE, req_ready is all-zero, regardless of req_valid.
- Operand 0 still takes the full W CALC cycles and returns 0.
- Reset at any point:
  - FSM goes to IDLE, last = N_REQ-1, and acc, op, id_q, step = 0.
  - Any in-flight operation is dropped and no response is issued.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Accept occurs in cycle t (IDLE, req_ready high).
- CALC occupies cycles t+1 .. t+W.
- rsp_valid first goes high at t+W+1, which is t+4 for W=3.
- With rsp_ready held high, the next accept can occur at t+W+2. Maximum throughput is one operation per W+2 cycles.
- busy rises in cycle t+1 and falls the cycle after the response handshake.
- rsp_data, rsp_id and rsp_valid are registered outputs.
- req_ready is combinational from req_valid, state and last. There is no combinational path from rsp_ready to req_ready.
- Events in the same cycle:
  - req_valid arriving while in RESP is ignored until IDLE.
  - A requester dropping req_valid in a non-accept cycle has no effect.

## Structure
- Package sq_sched_pkg holds:
  - the state enum (IDLE, CALC, RESP);
  - the default W and N_REQ;
  - the localparam for the id width.
- Sub-module rr_arbiter (N_REQ):
  - inputs: req vector, last pointer, enable;
  - outputs: one-hot grant and binary grant index;
  - purely combinational.
- sq_sched holds the FSM, the operand, acc and step registers, and the last pointer.

## Test plan
- After reset, with no requests: all outputs 0 for 10 cycles and busy=0. Then req_valid[0]=1, data 5 → accept in cycle t; rsp_valid at t+4 with rsp_data=25, rsp_id=0.
- All four requesters valid, with data 1, 2, 3, 7, and rsp_ready tied high → responses in id order 0, 1, 2, 3 with values 1, 4, 9, 49. Accepts are spaced 5 cycles apart.
- Requesters 0 and 2 held continuously valid (data 6 and 7) → grants alternate 0, 2, 0, 2, and responses alternate 36, 49, 36, 49. Requester 1, raised later, gets the next turn after the current holder.
- Backpressure: rsp_ready low for 6 cycles after rsp_valid rises → rsp_valid, rsp_data and rsp_id stay stable. No req_ready pulses occur while any req_valid is high. Accept resumes the cycle after the handshake.
- Reset asserted in the second CALC cycle → the next cycle shows IDLE with all outputs 0 and no stale response. The next request from requester 3, data 4, is granted to id 3 (pointer reset) and returns 16.
- Operand 0 from requester 1 → response 0 after the full 4-cycle latency, with rsp_id=1.

Source files
------------

// File: rtl/sq_sched_pkg.sv
// Shared types and default sizing for the round-robin squarer scheduler.
package sq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SQ_N_REQ = 4;
  localparam int SQ_W     = 3;
  localparam int SQ_ID_W  = $clog2(SQ_N_REQ);

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sq_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... and grants the first valid request.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_idx
);

  always_comb begin
    int  w_idx;
    logic w_found;
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_grant[w_idx]   = 1'b1;
        o_grant_idx      = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/sq_sched.sv
// Round-robin scheduler feeding one shift-add squarer; one partial product per CALC cycle.
module sq_sched
  import sq_sched_pkg::*;
#(
  parameter int N_REQ = SQ_N_REQ,
  parameter int W     = SQ_W,
  parameter int ID_W  = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [2*W-1:0]     rsp_data,
  input  logic               rsp_ready,
  output logic               busy
);

  localparam int STEP_W = idx_w(W);

  // Handshake: a transfer happens on any cycle where valid and ready are both high.
  // Requesters hold valid/data until their ready bit is seen; the response is held until rsp_ready.

  state_t             r_state;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_id_q;
  logic [W-1:0]       r_op;
  logic [2*W-1:0]     r_acc;
  logic [STEP_W-1:0]  r_step;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [2*W-1:0]     r_rsp_data;

  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_accept;
  logic [W-1:0]       w_op_sel;
  logic [2*W-1:0]     w_op_ext;
  logic [2*W-1:0]     w_pp;
  logic [2*W-1:0]     w_acc_next;
  logic               w_last_step;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_last      (r_last),
    .i_en        (r_state == IDLE),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_accept = |w_grant;

  always_comb begin
    w_op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_op_sel = req_data[i*W +: W];
    end
  end

  assign w_op_ext    = {{W{1'b0}}, r_op};
  assign w_pp        = r_op[r_step] ? (w_op_ext << r_step) : '0;
  assign w_acc_next  = r_acc + w_pp;
  assign w_last_step = (r_step == STEP_W'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= ID_W'(N_REQ - 1);
      r_id_q      <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_op_sel;
            r_id_q  <= w_grant_idx;
            r_last  <= w_grant_idx;
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + STEP_W'(1);
          // The response registers load the final sum directly so RESP outputs are registered.
          if (w_last_step) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_acc_next;
            r_rsp_id    <= r_id_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sq_sched.sv
// Bench for sq_sched: round-robin/latency reference model, scoreboard queue and response monitor.
module tb_sq_sched;
  import sq_sched_pkg::*;

  localparam int N    = SQ_N_REQ;
  localparam int W    = SQ_W;
  localparam int ID_W = SQ_ID_W;
  localparam int DW   = 2 * W;
  localparam int EW   = ID_W + DW;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready;
  logic              busy;

  logic [N-1:0]      rv;
  logic [W-1:0]      rd [N];
  logic [N-1:0]      hold;

  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     rsp_log[$];

  int cmp_cnt = 0;
  int err_cnt = 0;

  bit            m_free   = 1'b1;
  int            m_last   = N - 1;
  int            m_rsp_at = 0;
  int            cyc      = 0;
  logic [N-1:0]  m_acc    = '0;

  sq_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req_valid = rv;
  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = rd[i];
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sq(input logic [W-1:0] v);
    int x;
    x = int'(v);
    return DW'(x * x);
  endfunction

  function automatic logic [EW-1:0] ent(input int id, input int val);
    return {ID_W'(id), DW'(val)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (m_acc[i] && !hold[i]) rv[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    rv   = '0;
    hold = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !m_free || rv != '0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {req_ready, rsp_valid, rsp_id, rsp_data, busy}, 32'd0);
  endtask

  // ---------------- reference model ----------------
  // Round-robin from last+1, one op in flight, response W+1 cycles after accept.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    int           win;
    bit           ev;
    if (rst) begin
      m_free = 1'b1;
      m_last = N - 1;
      m_acc  = '0;
      exp_q.delete();
    end else begin
      eg  = '0;
      win = -1;
      if (m_free) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (win < 0 && rv[idx]) win = idx;
        end
      end
      if (win >= 0) eg[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("busy", 32'(busy), 32'(!m_free));
      ev = !m_free && (cyc >= m_rsp_at);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      m_acc = eg;
      if (ev && rsp_ready) m_free = 1'b1;
      if (win >= 0) begin
        exp_q.push_back({ID_W'(win), sq(rd[win])});
        m_free   = 1'b0;
        m_rsp_at = cyc + W + 1;
        m_last   = win;
      end
    end
    cyc++;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_rsp: got id %0d data %0d expected no response", rsp_id, rsp_data);
      end else begin
        e = exp_q[0];
        chk("rsp_id", 32'(rsp_id), 32'(e[EW-1:DW]));
        chk("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          rsp_log.push_back({rsp_id, rsp_data});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst       = 1'b1;
    rv        = '0;
    hold      = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) rd[i] = '0;

    // Reset state, then a single request: 5*5 = 25 from id 0
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk_idle_outputs("reset_idle");
      step();
    end
    rsp_log.delete();
    rd[0] = W'(5);
    rv[0] = 1'b1;
    drain(40);
    chk("t1_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() == 1) chk("t1_rsp", 32'(rsp_log[0]), 32'(ent(0, 25)));

    // All four requesters at once: id order 0..3, squares 1,4,9,49
    do_reset();
    rsp_log.delete();
    rd[0] = W'(1); rd[1] = W'(2); rd[2] = W'(3); rd[3] = W'(7);
    rv = '1;
    drain(80);
    chk("t2_count", 32'(rsp_log.size()), 32'd4);
    if (rsp_log.size() == 4) begin
      chk("t2_rsp0", 32'(rsp_log[0]), 32'(ent(0, 1)));
      chk("t2_rsp1", 32'(rsp_log[1]), 32'(ent(1, 4)));
      chk("t2_rsp2", 32'(rsp_log[2]), 32'(ent(2, 9)));
      chk("t2_rsp3", 32'(rsp_log[3]), 32'(ent(3, 49)));
    end

    // Requesters 0 and 2 held valid: alternate 36, 49; then requester 1 joins
    do_reset();
    rsp_log.delete();
    rd[0] = W'(6); rd[2] = W'(7);
    hold[0] = 1'b1; hold[2] = 1'b1;
    rv[0] = 1'b1; rv[2] = 1'b1;
    n = 0;
    while (rsp_log.size() < 4 && n < 60) begin
      step();
      n++;
    end
    chk("t3_wait", 32'(n < 60), 32'd1);
    if (rsp_log.size() >= 4) begin
      chk("t3_rsp0", 32'(rsp_log[0]), 32'(ent(0, 36)));
      chk("t3_rsp1", 32'(rsp_log[1]), 32'(ent(2, 49)));
      chk("t3_rsp2", 32'(rsp_log[2]), 32'(ent(0, 36)));
      chk("t3_rsp3", 32'(rsp_log[3]), 32'(ent(2, 49)));
    end
    rd[1] = W'(3);
    rv[1] = 1'b1;
    repeat (25) step();
    hold = '0;
    rv   = '0;
    drain(40);

    // Backpressure: response held 6 cycles, pending request 2 must wait
    do_reset();
    rsp_log.delete();
    rsp_ready = 1'b0;
    rd[1] = W'(6); rd[2] = W'(5);
    rv[1] = 1'b1; rv[2] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("t4_wait", 32'(n < 20), 32'd1);
    repeat (6) step();
    rsp_ready = 1'b1;
    drain(40);
    chk("t4_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) begin
      chk("t4_rsp0", 32'(rsp_log[0]), 32'(ent(1, 36)));
      chk("t4_rsp1", 32'(rsp_log[1]), 32'(ent(2, 25)));
    end

    // Reset in the second CALC cycle drops the operation; pointer restarts
    do_reset();
    rsp_log.delete();
    rd[0] = W'(5);
    rv[0] = 1'b1;
    step();          // accept cycle ends here
    step();          // first CALC cycle ends here
    rst = 1'b1;
    step();          // reset sampled at the end of the second CALC cycle
    rst = 1'b0;
    chk_idle_outputs("t5_after_reset");
    rd[3] = W'(4);
    rv[3] = 1'b1;
    drain(40);
    chk("t5_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() == 1) chk("t5_rsp", 32'(rsp_log[0]), 32'(ent(3, 16)));

    // Operand 0 still returns after the full latency
    rsp_log.delete();
    rd[1] = W'(0);
    rv[1] = 1'b1;
    drain(40);
    chk("t6_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() == 1) chk("t6_rsp", 32'(rsp_log[0]), 32'(ent(1, 0)));

    // Randomized traffic with random backpressure and withdrawn requests
    repeat (500) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            rd[i] = W'($urandom_range(0, (1 << W) - 1));
            rv[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rv        = '0;
    rsp_ready = 1'b1;
    drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
